network_lock_sequencer: RTL

//  Bring-up and gain scheduler for the 2x2 NetworkRing ADPLL array. Enables nodes 11,12,21,22 in

---
 rtl/network_lock_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/network_lock_sequencer.sv
// Bring-up and gain scheduler for the 2x2 NetworkRing ADPLL array.
// Ports: fpga_clk_i, reset_i (sync, active-high), start_i, stop_i,
//   error_i {22,21,12,11}; out node_enable_o, uni_dir_o, kp_o, ki_o,
//   state_o, locked_o, lock_lost_o, and lock_loss_cnt_o [7:0] when the
//   LOCK_STATS_EN macro is defined.
module network_lock_sequencer #(
    parameter int PDET_WIDTH     = 5,
    parameter int KP_WIDTH       = 5,
    parameter int KI_WIDTH       = 11,
    parameter int CNT_WIDTH      = 16,
    parameter int STAGE_CYCLES   = 256,
    parameter int LOCK_THRESH    = 2,
    parameter int LOCK_CYCLES    = 1024,
    parameter int LOSS_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 60000,
    parameter int ACQ_KP         = 8,
    parameter int ACQ_KI         = 64,
    parameter int TRK_KP         = 2,
    parameter int TRK_KI         = 4
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [4*PDET_WIDTH-1:0] error_i,
    output logic [3:0]              node_enable_o,
    output logic                    uni_dir_o,
    output logic [KP_WIDTH-1:0]     kp_o,
    output logic [KI_WIDTH-1:0]     ki_o,
    output logic [2:0]              state_o,
    output logic                    locked_o,
    output logic                    lock_lost_o
`ifdef LOCK_STATS_EN
    ,
    output logic [7:0]              lock_loss_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        ACQUIRE = 3'd2,
        TRACK   = 3'd3,
        LOCKED  = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [KP_WIDTH-1:0] KP_ACQ = KP_WIDTH'(ACQ_KP);
    localparam logic [KI_WIDTH-1:0] KI_ACQ = KI_WIDTH'(ACQ_KI);
    localparam logic [KP_WIDTH-1:0] KP_TRK = KP_WIDTH'(TRK_KP);
    localparam logic [KI_WIDTH-1:0] KI_TRK = KI_WIDTH'(TRK_KI);

    localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST  = CNT_WIDTH'(LOCK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOSS_LAST  = CNT_WIDTH'(LOSS_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PDET_WIDTH-1:0] THRESH    = PDET_WIDTH'(LOCK_THRESH);

    state_t                 state_q, state_d;
    logic [3:0]             en_q, en_d;
    logic                   uni_q, uni_d;
    logic [KP_WIDTH-1:0]    kp_q, kp_d;
    logic [KI_WIDTH-1:0]    ki_q, ki_d;
    logic                   locked_q, locked_d;
    logic                   lost_q, lost_d;
    logic [CNT_WIDTH-1:0]   stage_q, stage_d;
    logic [CNT_WIDTH-1:0]   lock_q, lock_d;
    logic [CNT_WIDTH-1:0]   loss_q, loss_d;
    logic [CNT_WIDTH-1:0]   tmo_q, tmo_d;
    logic [3:0]             node_ok;
    logic                   in_band;

    // Magnitude of a signed error; the most-negative code has no positive
    // twin, so it is clamped to the largest positive value.
    function automatic logic [PDET_WIDTH-1:0] abs_sat(
        input logic [PDET_WIDTH-1:0] x
    );
        if (x == {1'b1, {(PDET_WIDTH-1){1'b0}}})
            return {1'b0, {(PDET_WIDTH-1){1'b1}}};
        else if (x[PDET_WIDTH-1])
            return ~x + 1'b1;
        else
            return x;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] x
    );
        return (x == {CNT_WIDTH{1'b1}}) ? x : x + 1'b1;
    endfunction

    // A disabled node never blocks lock.
    for (genvar n = 0; n < 4; n++) begin : g_band
        assign node_ok[n] = !en_q[n] ||
            (abs_sat(error_i[n*PDET_WIDTH +: PDET_WIDTH]) <= THRESH);
    end
    assign in_band = &node_ok;

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        uni_d    = uni_q;
        kp_d     = kp_q;
        ki_d     = ki_q;
        locked_d = 1'b0;
        lost_d   = 1'b0;
        stage_d  = stage_q;
        lock_d   = lock_q;
        loss_d   = loss_q;
        tmo_d    = tmo_q;
        if (stop_i) begin
            state_d = IDLE;
            en_d    = 4'b0000;
            uni_d   = 1'b1;
            kp_d    = KP_ACQ;
            ki_d    = KI_ACQ;
            stage_d = '0;
            lock_d  = '0;
            loss_d  = '0;
            tmo_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    en_d = 4'b0000;
                    if (start_i) begin
                        state_d = RAMP;
                        en_d    = 4'b0001;
                        stage_d = '0;
                    end
                end
                RAMP: begin
                    if (stage_q == STAGE_LAST) begin
                        stage_d = '0;
                        if (en_q == 4'b1111) begin
                            state_d = ACQUIRE;
                            lock_d  = '0;
                            tmo_d   = '0;
                        end else begin
                            en_d = {en_q[2:0], 1'b1};
                        end
                    end else begin
                        stage_d = sat_inc(stage_q);
                    end
                end
                ACQUIRE, TRACK: begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = FAULT;
                    end else begin
                        tmo_d = sat_inc(tmo_q);
                        if (!in_band) begin
                            lock_d = '0;
                        end else if (lock_q != LOCK_LAST) begin
                            lock_d = sat_inc(lock_q);
                        end else if (state_q == ACQUIRE) begin
                            state_d = TRACK;
                            lock_d  = '0;
                            uni_d   = 1'b0;
                            kp_d    = KP_TRK;
                            ki_d    = KI_TRK;
                        end else begin
                            state_d  = LOCKED;
                            lock_d   = '0;
                            loss_d   = '0;
                            locked_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    locked_d = 1'b1;
                    if (in_band) begin
                        loss_d = '0;
                    end else if (loss_q != LOSS_LAST) begin
                        loss_d = sat_inc(loss_q);
                    end else begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                        uni_d    = 1'b1;
                        kp_d     = KP_ACQ;
                        ki_d     = KI_ACQ;
                        loss_d   = '0;
                        lock_d   = '0;
                        tmo_d    = '0;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            en_q     <= 4'b0000;
            uni_q    <= 1'b1;
            kp_q     <= KP_ACQ;
            ki_q     <= KI_ACQ;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            stage_q  <= '0;
            lock_q   <= '0;
            loss_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            uni_q    <= uni_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
            stage_q  <= stage_d;
            lock_q   <= lock_d;
            loss_q   <= loss_d;
            tmo_q    <= tmo_d;
        end
    end

`ifdef LOCK_STATS_EN
    logic [7:0] stats_q;

    // Survives stop_i so loss history outlives a manual restart.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i)
            stats_q <= 8'd0;
        else if (lost_q && stats_q != 8'hFF)
            stats_q <= stats_q + 8'd1;
    end

    assign lock_loss_cnt_o = stats_q;
`endif

    assign state_o       = state_q;
    assign node_enable_o = en_q;
    assign uni_dir_o     = uni_q;
    assign kp_o          = kp_q;
    assign ki_o          = ki_q;
    assign locked_o      = locked_q;
    assign lock_lost_o   = lost_q;

endmodule
